serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial N-bit adder built around one instance of the existing 1-bit fulladder cell.
//   Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
//   Adds them LSB-first, one bit per clock, through the single fulladder, with the carry held in a flop.
//   Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
//   Sits as the sequencing stage in front of fulladder: the area-cheap alternative to a ripple chain.
// PARAMETERS
//   WIDTH  8  operand/sum width in bits; legal range WIDTH >= 2
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands a/b/cin are valid
//   in_ready   out  1      block can accept operands
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in to bit 0
//   out_valid  out  1      sum/cout are valid
//   out_ready  in   1      downstream accepts the result
//   sum        out  WIDTH  (a + b + cin) mod 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//   - FSM states: IDLE, RUN, DONE.
//   - Reset (rst=1 at an edge): state=IDLE, carry=0, cnt=0, sum register=0, cout=0, out_valid=0.
//   - in_ready = (state==IDLE) && !rst. It is combinational and is 0 while rst is high.
//   - IDLE: on an edge with in_valid && in_ready:
//       load a_sh=a, b_sh=b, carry=cin, cnt=0; go to RUN.
//       Otherwise stay in IDLE.
//   - RUN: every edge:
//       fulladder inputs are a_sh[0], b_sh[0], carry.
//       sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]}; carry <= fa_cout.
//       a_sh >>= 1, b_sh >>= 1; cnt <= cnt+1.
//       On the edge where cnt==WIDTH-1, go to DONE.
//   - RUN lasts exactly WIDTH edges.
//   - Latency: out_valid rises exactly WIDTH clocks after the accepting edge.
//   - DONE: out_valid=1; sum=sum_sh; cout=carry.
//       Both outputs hold stable while out_ready=0.
//       On an edge with out_ready=1, go to IDLE; out_valid drops the next cycle.
//   - Throughput: at most one operation per WIDTH+2 clocks. No overlap.
//       in_valid is ignored in RUN and DONE, including an edge where out_ready=1 in DONE.
//       That operand is taken in IDLE on the next cycle.
//   - Width rule: {cout,sum} == a + b + cin exactly, computed as a (WIDTH+1)-bit result.
//       No saturation.
//   - cnt is $clog2(WIDTH) bits wide and never wraps past WIDTH-1.
//   - Reset mid-RUN or mid-DONE aborts the operation: no out_valid for it, internal state cleared.
//       in_ready is 1 in the first cycle after rst deasserts.
//   - sum/cout carry no meaning while out_valid=0. Verification must only check them when out_valid=1.
// STRUCTURE
//   - Shared package serial_adder_pkg: state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
//     Any later serial-arithmetic block reuses it.
//   - One sub-module: the existing fulladder (ports a, b, cin, sum, cout), instantiated once.
//   - Everything else is local: shift registers, carry flop, counter, FSM.
// TESTING (WIDTH=8 unless stated; cin=0 unless stated)
//   1. a=8'h00, b=8'h00 -> sum=8'h00, cout=0.
//      out_valid high exactly 8 clocks after the accept edge.
//   2. a=8'hFF, b=8'h01 -> sum=8'h00, cout=1 (carry propagates through all bits).
//   3. a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//   4. a=8'h5A, b=8'hA5, out_ready held 0 for 5 cycles -> sum=8'hFF, cout=0, stable throughout.
//      in_ready=0; an in_valid with a=8'h11 during that window is ignored.
//   5. Start a=8'h12, b=8'h34, assert rst on the 3rd RUN cycle -> out_valid never rises.
//      After rst drops: in_ready=1; a=8'h12, b=8'h34, cin=1 -> sum=8'h47, cout=0.
//   6. WIDTH=4: exhaustive sweep of all 512 {a,b,cin} combinations, random out_ready stalls.
//      Every {cout,sum} equals a+b+cin; exactly 512 results, in order.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// counter sizing helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } sa_state_e;

  // Bit-count register width; never narrower than one bit.
  function automatic int unsigned sa_cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell; the one arithmetic element of the serial adder.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift out LSB-first through one full
// adder, the carry lives in a flop, and the sum shifts in from the top.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned   CntW    = sa_cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  sa_state_e        state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic             out_valid_q;
  logic             fa_sum;
  logic             fa_cout;

  fulladder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = out_valid_q;
  assign sum       = sum_sh_q;
  assign cout      = carry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_sh_q <= {fa_sum, sum_sh_q[WIDTH-1:1]};
          carry_q  <= fa_cout;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          if (cnt_q == CntLast) begin
            // Counter parks at zero so it never wraps past the last bit.
            cnt_q       <= '0;
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed WIDTH=8 cases, random
// WIDTH=8 traffic, and an in-order exhaustive WIDTH=4 sweep with stalls.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4;
  logic [3:0] a4, b4, sum4;

  int tests = 0;
  int fails = 0;
  logic [8:0] q8[$];
  int res4 = 0;
  bit done8 = 1'b0;
  bit done4 = 1'b0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: every result equals the plain sum of the accepted operands,
  // delivered in acceptance order; a reset discards anything in flight.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        q8.delete();
      end else begin
        if (out_valid8) begin
          if (q8.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL dut8 unexpected out_valid: got sum %0h cout %0b, expected none",
                     sum8, cout8);
          end else begin
            check("dut8 result", {23'd0, cout8, sum8}, {23'd0, q8[0]});
            if (out_ready8) void'(q8.pop_front());
          end
        end
        if (in_valid8 && in_ready8) q8.push_back(9'(a8) + 9'(b8) + 9'(cin8));
        if (out_valid4) begin
          check("dut4 in-order result", {27'd0, cout4, sum4},
                32'((res4 & 15) + ((res4 >> 4) & 15) + (res4 >> 8)));
          if (out_ready4) res4++;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n = 0;
    a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
    @(negedge clk);
    while (!in_ready8 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready8) begin
      tests++;
      fails++;
      $display("FAIL dut8 accept timeout: in_ready got 0, expected 1");
      in_valid8 = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid8 = 1'b0;
  endtask

  task automatic send4(input int i);
    int n = 0;
    a4 = i[3:0]; b4 = i[7:4]; cin4 = i[8]; in_valid4 = 1'b1;
    @(negedge clk);
    while (!in_ready4 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready4) begin
      tests++;
      fails++;
      $display("FAIL dut4 accept timeout: in_ready got 0, expected 1");
      in_valid4 = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid4 = 1'b0;
  endtask

  // Called right after an accept edge; counts clocks until out_valid is seen.
  task automatic wait_valid8(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid8 && lat < 40) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic directed(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [7:0] exp_sum, input logic exp_cout);
    int lat;
    out_ready8 = 1'b1;
    send8(a, b, c);
    wait_valid8(lat);
    check({name, " latency"}, lat, 8);
    check({name, " sum"}, sum8, exp_sum);
    check({name, " cout"}, cout8, exp_cout);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({name, " out_valid drop"}, out_valid8, 1'b0);
    check({name, " in_ready back"}, in_ready8, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int n;
    rst = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("in_ready held low in reset", in_ready8, 1'b0);
    check("dut4 in_ready held low in reset", in_ready4, 1'b0);
    check("out_valid after reset", out_valid8, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready after reset", in_ready8, 1'b1);
    @(posedge clk);
    #1;

    directed("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    directed("full carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    directed("max plus cin", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Backpressure: result must hold, and a new operand must wait for IDLE.
    out_ready8 = 1'b0;
    send8(8'h5A, 8'hA5, 1'b0);
    wait_valid8(lat);
    check("stall latency", lat, 8);
    for (int k = 0; k < 5; k++) begin
      check("stall out_valid", out_valid8, 1'b1);
      check("stall sum", sum8, 8'hFF);
      check("stall cout", cout8, 1'b0);
      check("stall in_ready", in_ready8, 1'b0);
      @(posedge clk);
      #1;
      if (k == 0) begin
        a8 = 8'h11; b8 = 8'h00; cin8 = 1'b0; in_valid8 = 1'b1;
      end
    end
    out_ready8 = 1'b1;
    @(negedge clk);
    check("stall in_ready on release", in_ready8, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("in_ready after release", in_ready8, 1'b1);
    check("out_valid after release", out_valid8, 1'b0);
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    wait_valid8(lat);
    check("late operand latency", lat, 8);
    check("late operand sum", sum8, 8'h11);
    @(posedge clk);
    #1;

    // Reset during RUN aborts the operation.
    send8(8'h12, 8'h34, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("in_ready during abort reset", in_ready8, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready after abort", in_ready8, 1'b1);
    for (int k = 0; k < 12; k++) begin
      check("no out_valid after abort", out_valid8, 1'b0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    directed("after abort", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

    // Random WIDTH=8 traffic with random backpressure.
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          send8(8'($urandom), 8'($urandom), 1'($urandom));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        n = 0;
        while (q8.size() != 0 && n < 200) begin
          n++;
          @(posedge clk);
        end
        check("dut8 random drain", q8.size(), 0);
        done8 = 1'b1;
      end
      begin
        while (!done8) begin
          @(posedge clk);
          #1 out_ready8 = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready8 = 1'b1;

    // Exhaustive WIDTH=4 sweep in order.
    fork
      begin
        for (int i = 0; i < 512; i++) begin
          send4(i);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        n = 0;
        while (res4 < 512 && n < 200) begin
          n++;
          @(posedge clk);
        end
        done4 = 1'b1;
      end
      begin
        while (!done4) begin
          @(posedge clk);
          #1 out_ready4 = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready4 = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("dut4 result count", res4, 512);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
